// File: rtl/adc_scan_ctrl.sv
// adc_scan_ctrl
//   Scan sequencer for the arm's 8-channel ADC front end. Each round is
//   started by a divided tick. It converts either every channel enabled in
//   ch_mask, in ascending order (auto), or the single encoder-selected channel
//   (manual). Results go into per-channel registers, which are read back
//   through a registered read port.
//
//   Optional build macro: ADC_SCAN_AVG_EN. When defined, every selected
//   channel is converted 4 times and the truncated mean is stored.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   enable                run scan rounds while high
//   manual, man_chan      manual mode and encoder channel (8..15 clamp to 7)
//   ch_mask               auto-scan channel enables
//   adc_start, adc_chan   conversion request pulse and its channel
//   adc_busy              driver busy (no start while high)
//   adc_done, adc_data    sample-valid pulse and sample
//   rd_chan               result read address
//   rd_data, rd_valid     registered result and valid flag for rd_chan
//   scan_done             one-cycle pulse when a round completes
//   timeout_err, clr_err  sticky conversion-timeout flag and its clear
//   fsm_state             current sequencer state, for observation
//
// Driver handshake: a request is accepted in the cycle where adc_start=1,
// and adc_start is only raised when adc_busy=0. After that, the sample is
// taken in the first cycle with adc_done=1. If adc_done does not come within
// TIMEOUT cycles, the conversion is abandoned.

module adc_scan_ctrl #(
   parameter int NUM_CH   = 8,
   parameter int DATA_W   = 12,
   parameter int SCAN_DIV = 1000,
   parameter int TIMEOUT  = 255
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              enable,
   input  logic              manual,
   input  logic [3:0]        man_chan,
   input  logic [NUM_CH-1:0] ch_mask,
   output logic              adc_start,
   output logic [2:0]        adc_chan,
   input  logic              adc_busy,
   input  logic              adc_done,
   input  logic [DATA_W-1:0] adc_data,
   input  logic [2:0]        rd_chan,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              scan_done,
   output logic              timeout_err,
   input  logic              clr_err,
   output logic [2:0]        fsm_state
);

   localparam int CNT_W = $clog2(SCAN_DIV);
   localparam int TO_W  = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_SELECT  = 3'd1;
   localparam logic [2:0] S_START   = 3'd2;
   localparam logic [2:0] S_CONVERT = 3'd3;
   localparam logic [2:0] S_DONE    = 3'd4;

   logic [2:0]        state;
   logic [CNT_W-1:0]  tick_cnt;
   logic              tick;
   logic [TO_W-1:0]   to_cnt;
   logic [3:0]        ptr;          // next channel to consider; 8 = none left
   logic              snap_manual;
   logic [NUM_CH-1:0] snap_mask;
   logic [2:0]        snap_chan;
   logic [DATA_W-1:0] res_mem [NUM_CH];
   logic [NUM_CH-1:0] res_valid;

   logic              pick_found;
   logic [2:0]        pick_chan;
   logic              conv_done;
   logic              conv_to;
   logic              wr_en;
   logic [DATA_W-1:0] wr_data;
   logic              chan_fin;

`ifdef ADC_SCAN_AVG_EN
   logic [DATA_W+1:0] acc;
   logic [1:0]        idx;
   logic [DATA_W+1:0] sum_next;
`endif

   assign fsm_state = state;
   assign adc_start = (state == S_START) && !adc_busy;
   assign scan_done = (state == S_DONE);

   // Round tick divider
   assign tick = enable && (tick_cnt == CNT_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         tick_cnt <= '0;
      else if (!enable || tick_cnt == CNT_LAST)
         tick_cnt <= '0;
      else
         tick_cnt <= tick_cnt + 1'b1;
   end

   // Channel pick. Manual rounds convert once (ptr is still 0). Auto rounds
   // take the lowest enabled channel at or above ptr. The loop runs downward,
   // so the last match it finds is the lowest one.
   always_comb begin
      pick_found = 1'b0;
      pick_chan  = '0;
      if (snap_manual) begin
         pick_found = (ptr == 4'd0);
         pick_chan  = snap_chan;
      end else begin
         for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (snap_mask[i] && (4'(i) >= ptr)) begin
               pick_found = 1'b1;
               pick_chan  = 3'(i);
            end
         end
      end
   end

   // Conversion outcome. The done pulse wins over a timeout in the same cycle.
   assign conv_done = (state == S_CONVERT) && adc_done;
   assign conv_to   = (state == S_CONVERT) && !adc_done && (to_cnt == TO_LAST);

`ifdef ADC_SCAN_AVG_EN
   assign sum_next = acc + {2'b00, adc_data};
   assign wr_en    = conv_done && (idx == 2'd3);
   assign wr_data  = sum_next[DATA_W+1:2];
`else
   assign wr_en    = conv_done;
   assign wr_data  = adc_data;
`endif
   assign chan_fin = wr_en || conv_to;

   // Sequencer
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= S_IDLE;
         ptr         <= '0;
         snap_manual <= 1'b0;
         snap_mask   <= '0;
         snap_chan   <= '0;
         adc_chan    <= '0;
         to_cnt      <= '0;
`ifdef ADC_SCAN_AVG_EN
         acc         <= '0;
         idx         <= '0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (tick) begin
                  snap_manual <= manual;
                  snap_mask   <= ch_mask;
                  snap_chan   <= man_chan[3] ? 3'd7 : man_chan[2:0];
                  ptr         <= '0;
                  state       <= S_SELECT;
               end
            end
            S_SELECT: begin
               // enable is only checked between conversions, so a running
               // conversion is never cut off.
               if (!enable) begin
                  state <= S_IDLE;
               end else if (!pick_found) begin
                  state <= S_DONE;
               end else begin
                  adc_chan <= pick_chan;
                  state    <= S_START;
`ifdef ADC_SCAN_AVG_EN
                  acc      <= '0;
                  idx      <= '0;
`endif
               end
            end
            S_START: begin
               if (!adc_busy) begin
                  to_cnt <= '0;
                  state  <= S_CONVERT;
               end
            end
            S_CONVERT: begin
               if (chan_fin) begin
                  ptr   <= {1'b0, adc_chan} + 4'd1;
                  state <= S_SELECT;
               end
`ifdef ADC_SCAN_AVG_EN
               else if (conv_done) begin
                  acc   <= sum_next;
                  idx   <= idx + 2'd1;
                  state <= S_START;
               end
`endif
               else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Result store, read port and error flag
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_CH; i++) res_mem[i] <= '0;
         res_valid   <= '0;
         rd_data     <= '0;
         rd_valid    <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         if (wr_en) begin
            res_mem[adc_chan]   <= wr_data;
            res_valid[adc_chan] <= 1'b1;
         end else if (conv_to) begin
            res_valid[adc_chan] <= 1'b0;
         end

         // Bypass, so a result written this cycle shows up on the next one
         if (wr_en && rd_chan == adc_chan)
            rd_data <= wr_data;
         else
            rd_data <= res_mem[rd_chan];

         if (chan_fin && rd_chan == adc_chan)
            rd_valid <= wr_en;
         else
            rd_valid <= res_valid[rd_chan];

         if (conv_to)
            timeout_err <= 1'b1;
         else if (clr_err)
            timeout_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Testbench for adc_scan_ctrl (SCAN_DIV=16, TIMEOUT=20).
// Behavioural ADC model: adc_done arrives 5 cycles after adc_start, with data
// data_base+chan, or the next entry of samp_q. The model ignores channel
// no_resp.

module tb_adc_scan_ctrl;

   localparam int DATA_W = 12;
`ifdef ADC_SCAN_AVG_EN
   localparam int REP = 4;
`else
   localparam int REP = 1;
`endif

   logic              clk;
   logic              reset_n;
   logic              enable;
   logic              manual;
   logic [3:0]        man_chan;
   logic [7:0]        ch_mask;
   logic              adc_start;
   logic [2:0]        adc_chan;
   logic              adc_busy;
   logic              adc_done;
   logic [DATA_W-1:0] adc_data;
   logic [2:0]        rd_chan;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              scan_done;
   logic              timeout_err;
   logic              clr_err;
   logic [2:0]        fsm_state;

   adc_scan_ctrl #(
      .NUM_CH(8), .DATA_W(DATA_W), .SCAN_DIV(16), .TIMEOUT(20)
   ) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .manual(manual),
      .man_chan(man_chan), .ch_mask(ch_mask), .adc_start(adc_start),
      .adc_chan(adc_chan), .adc_busy(adc_busy), .adc_done(adc_done),
      .adc_data(adc_data), .rd_chan(rd_chan), .rd_data(rd_data),
      .rd_valid(rd_valid), .scan_done(scan_done), .timeout_err(timeout_err),
      .clr_err(clr_err), .fsm_state(fsm_state)
   );

   // Clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: cycle count, start log, scan_done count
   int          cyc = 0;
   int          done_cnt = 0;
   logic [2:0]  st_ch[$];
   int          st_cyc[$];
   logic [2:0]  exp_q[$];

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial forever begin
      @(negedge clk);
      if (reset_n && adc_start) begin
         st_ch.push_back(adc_chan);
         st_cyc.push_back(cyc);
      end
      if (reset_n && scan_done) done_cnt++;
   end

   // ADC driver model
   int                no_resp = -1;
   logic [DATA_W-1:0] data_base = 12'h100;
   logic [DATA_W-1:0] samp_q[$];

   initial begin : adc_model
      logic [2:0] ch;
      adc_done = 1'b0;
      adc_data = '0;
      forever begin
         @(negedge clk);
         if (reset_n && adc_start && int'(adc_chan) != no_resp) begin
            ch = adc_chan;
            repeat (5) @(posedge clk);
            #1;
            if (samp_q.size() > 0) adc_data = samp_q.pop_front();
            else                   adc_data = data_base + 12'(ch);
            adc_done = 1'b1;
            @(posedge clk);
            #1;
            adc_done = 1'b0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Driver tasks
   task automatic clear_log();
      st_ch.delete();
      st_cyc.delete();
      exp_q.delete();
   endtask

   task automatic wait_done(input int budget, input int d0, output bit got);
      got = 1'b0;
      for (int k = 0; k < budget; k++) begin
         @(posedge clk);
         if (done_cnt > d0) begin
            got = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_start(input int budget, output bit got);
      got = 1'b0;
      for (int k = 0; k < budget; k++) begin
         @(posedge clk);
         if (st_ch.size() > 0) begin
            got = 1'b1;
            break;
         end
      end
   endtask

   task automatic run_round(input int budget, output int en_cyc, output bit got);
      int d0;
      d0 = done_cnt;
      @(posedge clk); #1;
      enable = 1'b1;
      en_cyc = cyc;
      wait_done(budget, d0, got);
      #1;
      enable = 1'b0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [2:0] ch, output logic [DATA_W-1:0] d, output logic v);
      @(posedge clk); #1;
      rd_chan = ch;
      @(posedge clk);
      @(negedge clk);
      d = rd_data;
      v = rd_valid;
   endtask

   task automatic compare_chans(input string tag);
      logic [2:0] e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (st_ch.size() == 0) check({tag, "_chan_missing"}, 32'd0, 32'd1);
         else                   check({tag, "_chan"}, st_ch.pop_front(), e);
      end
   endtask

   // Vector table
   typedef struct {
      logic       manual;
      logic [3:0] man_chan;
      logic [7:0] mask;
      int         n;
      logic [23:0] chans;   // channel j in chans[3*j +: 3]
   } vec_t;

   vec_t vecs[6];

   initial begin
      int                en;
      int                d0;
      bit                got;
      logic [DATA_W-1:0] d;
      logic              v;
      string             tag;

      vecs[0] = '{1'b0, 4'd0,  8'b1010_0101, 4, {12'd0, 3'd7, 3'd5, 3'd2, 3'd0}};
      vecs[1] = '{1'b1, 4'd3,  8'h00,        1, {21'd0, 3'd3}};
      vecs[2] = '{1'b1, 4'd12, 8'hFF,        1, {21'd0, 3'd7}};
      vecs[3] = '{1'b0, 4'd0,  8'h00,        0, 24'd0};
      vecs[4] = '{1'b0, 4'd9,  8'b1000_0000, 1, {21'd0, 3'd7}};
      vecs[5] = '{1'b0, 4'd0,  8'b0100_1001, 3, {15'd0, 3'd6, 3'd3, 3'd0}};

      reset_n  = 1'b0;
      enable   = 1'b0;
      manual   = 1'b0;
      man_chan = '0;
      ch_mask  = '0;
      adc_busy = 1'b0;
      rd_chan  = '0;
      clr_err  = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_adc_start", adc_start, 0);
      check("rst_adc_chan", adc_chan, 0);
      check("rst_scan_done", scan_done, 0);
      check("rst_timeout_err", timeout_err, 0);
      check("rst_rd_data", rd_data, 0);
      check("rst_rd_valid", rd_valid, 0);
      check("rst_state", fsm_state, 0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Table-driven rounds
      for (int r = 0; r < 6; r++) begin
         tag = $sformatf("vec%0d", r);
         manual   = vecs[r].manual;
         man_chan = vecs[r].man_chan;
         ch_mask  = vecs[r].mask;
         clear_log();
         d0 = done_cnt;
         for (int j = 0; j < vecs[r].n; j++)
            for (int k = 0; k < REP; k++)
               exp_q.push_back(vecs[r].chans[3*j +: 3]);
         run_round(400, en, got);
         check({tag, "_round_done"}, got, 1);
         check({tag, "_scan_done_cnt"}, done_cnt - d0, 1);
         check({tag, "_start_cnt"}, st_ch.size(), vecs[r].n * REP);
         if (st_cyc.size() > 0)
            check({tag, "_start_latency"}, st_cyc[0] - en, 17);
         compare_chans(tag);
         for (int j = 0; j < vecs[r].n; j++) begin
            rd(vecs[r].chans[3*j +: 3], d, v);
            check({tag, "_rd_data"}, d, 12'h100 + 12'(vecs[r].chans[3*j +: 3]));
            check({tag, "_rd_valid"}, v, 1);
         end
      end

      // Read port: converted channel 5, never-converted channel 1
      rd(3'd5, d, v);
      check("rd5_data", d, 12'h105);
      check("rd5_valid", v, 1);
      rd(3'd1, d, v);
      check("rd1_valid", v, 0);

      // adc_busy held high across the tick
      manual = 1'b1; man_chan = 4'd0; clear_log();
      d0 = done_cnt;
      adc_busy = 1'b1;
      @(posedge clk); #1;
      enable = 1'b1;
      en = cyc;
      repeat (26) @(posedge clk);
      #1;
      check("busy_no_start", st_ch.size(), 0);
      adc_busy = 1'b0;
      wait_done(200, d0, got);
      #1;
      enable = 1'b0;
      check("busy_round_done", got, 1);
      check("busy_start_cnt", st_ch.size(), REP);
      if (st_cyc.size() > 0) check("busy_start_cycle", st_cyc[0] - en, 26);
      repeat (3) @(posedge clk);
      #1;

      // Timeout on channel 2
      manual = 1'b0; ch_mask = 8'b0000_1100; no_resp = 2; clear_log();
      d0 = done_cnt;
      run_round(400, en, got);
      check("to_round_done", got, 1);
      check("to_scan_done_cnt", done_cnt - d0, 1);
      check("to_start_cnt", st_ch.size(), 1 + REP);
      if (st_ch.size() >= 2) begin
         check("to_gap", st_cyc[1] - st_cyc[0], 22);
         check("to_first_chan", st_ch[0], 2);
         check("to_second_chan", st_ch[1], 3);
      end else begin
         check("to_gap_missing", st_ch.size(), 2);
      end
      @(negedge clk);
      check("to_err_set", timeout_err, 1);
      rd(3'd2, d, v);
      check("to_rd2_valid", v, 0);
      rd(3'd3, d, v);
      check("to_rd3_data", d, 12'h103);
      check("to_rd3_valid", v, 1);
      @(negedge clk);
      check("to_err_sticky", timeout_err, 1);
      @(posedge clk); #1;
      clr_err = 1'b1;
      @(posedge clk); #1;
      clr_err = 1'b0;
      @(negedge clk);
      check("clr_err", timeout_err, 0);
      no_resp = -1;

      // Snapshot: changes mid-round wait for the next round
      manual = 1'b0; ch_mask = 8'h03; clear_log();
      d0 = done_cnt;
      @(posedge clk); #1;
      enable = 1'b1;
      wait_start(60, got);
      check("snap_first_start", got, 1);
      #1;
      ch_mask = 8'hF0; manual = 1'b1; man_chan = 4'd6;
      wait_done(300, d0, got);
      #1;
      enable = 1'b0;
      check("snap_round_done", got, 1);
      for (int k = 0; k < REP; k++) exp_q.push_back(3'd0);
      for (int k = 0; k < REP; k++) exp_q.push_back(3'd1);
      check("snap_start_cnt", st_ch.size(), 2 * REP);
      compare_chans("snap");
      repeat (3) @(posedge clk);
      #1;

      // enable drops one cycle after the first start
      manual = 1'b0; ch_mask = 8'hFF; data_base = 12'h200; clear_log();
      d0 = done_cnt;
      @(posedge clk); #1;
      enable = 1'b1;
      wait_start(60, got);
      check("drop_first_start", got, 1);
      #1;
      enable = 1'b0;
      repeat (60) @(posedge clk);
      #1;
      check("drop_start_cnt", st_ch.size(), REP);
      check("drop_no_scan_done", done_cnt - d0, 0);
      check("drop_state_idle", fsm_state, 0);
      rd(3'd0, d, v);
      check("drop_rd0_data", d, 12'h200);
      check("drop_rd0_valid", v, 1);

      // Reset in the middle of a conversion
      ch_mask = 8'h02; data_base = 12'h300; clear_log();
      rd_chan = 3'd3;
      @(posedge clk); #1;
      enable = 1'b1;
      wait_start(60, got);
      check("rstc_first_start", got, 1);
      repeat (2) @(posedge clk);
      #1;
      check("rstc_chan_before", adc_chan, 1);
      check("rstc_valid_before", rd_valid, 1);
      reset_n = 1'b0;
      #1;
      check("rstc_adc_chan", adc_chan, 0);
      check("rstc_rd_valid", rd_valid, 0);
      check("rstc_rd_data", rd_data, 0);
      check("rstc_adc_start", adc_start, 0);
      check("rstc_scan_done", scan_done, 0);
      check("rstc_state", fsm_state, 0);
      enable = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      reset_n = 1'b1;
      rd(3'd3, d, v);
      check("rstc_rd3_valid", v, 0);
      rd(3'd0, d, v);
      check("rstc_rd0_valid", v, 0);
      check("rstc_rd0_data", d, 0);
      data_base = 12'h100;

`ifdef ADC_SCAN_AVG_EN
      // Four-sample average on channel 1: (100+101+102+104)>>2 = 101
      manual = 1'b1; man_chan = 4'd1; clear_log();
      samp_q.push_back(12'd100);
      samp_q.push_back(12'd101);
      samp_q.push_back(12'd102);
      samp_q.push_back(12'd104);
      for (int k = 0; k < 4; k++) exp_q.push_back(3'd1);
      d0 = done_cnt;
      run_round(400, en, got);
      check("avg_round_done", got, 1);
      check("avg_start_cnt", st_ch.size(), 4);
      compare_chans("avg");
      rd(3'd1, d, v);
      check("avg_rd1_data", d, 12'd101);
      check("avg_rd1_valid", v, 1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/adc_scan_ctrl.md
Name: adc_scan_ctrl

Overview:
- Sequences conversions on the robot arm's 8-channel ADC front end, one channel at a time, and stores per-channel results.
- Two modes:
  - Auto-scan: every enabled channel in ch_mask, scanned in ascending order.
  - Manual: only the channel currently selected by the encoder channel selector, fed in on man_chan.
- Sits between the encoder/channel-select logic and the ADC serial driver, which uses an adc_start/adc_busy/adc_done handshake.
- Results are read back through a registered per-channel read port.

Parameters:
- NUM_CH, 8, number of ADC channels (fixed 8; channel index is 3 bits).
- DATA_W, 12, ADC sample width.
- SCAN_DIV, 1000, clk cycles between scan-round triggers (>=2).
- TIMEOUT, 255, max cycles waited for adc_done before abandoning a conversion (>=1).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  run scans while high.
- manual  in  1  1 = convert man_chan only; 0 = auto-scan ch_mask.
- man_chan  in  4  encoder-selected channel, 0..7; values 8..15 are treated as 7.
- ch_mask  in  NUM_CH  auto-scan enable, one bit per channel.
- adc_start  out  1  one-cycle conversion request.
- adc_chan  out  3  channel for the current conversion.
- adc_busy  in  1  driver busy; start must not be issued while high.
- adc_done  in  1  one-cycle pulse, sample valid on adc_data.
- adc_data  in  DATA_W  conversion result.
- rd_chan  in  3  result read address.
- rd_data  out  DATA_W  stored result for rd_chan.
- rd_valid  out  1  stored result for rd_chan is valid.
- scan_done  out  1  one-cycle pulse at the end of a completed round.
- timeout_err  out  1  sticky; set when a conversion times out.
- clr_err  in  1  clears timeout_err.

Behaviour:
- Reset values: all outputs 0; every result register 0; every valid bit 0; tick counter 0; FSM in IDLE.
- Tick counter:
  - Counts 0..SCAN_DIV-1 while enable=1 and holds at 0 while enable=0.
  - tick is asserted for one cycle when the count is SCAN_DIV-1.
- FSM states:
  - IDLE
    - On enable & tick: latch manual, ch_mask and clamped man_chan into a round snapshot; set ptr=0; go to SELECT.
    - Ticks arriving outside IDLE are dropped.
  - SELECT
    - Manual snapshot: pick the man_chan snapshot once.
    - Auto snapshot: pick the lowest enabled channel >= ptr.
    - If no channel remains (including mask=0): go to DONE.
    - Otherwise drive adc_chan with the picked channel and go to START.
  - START
    - Wait while adc_busy=1.
    - When adc_busy=0: assert adc_start for exactly one cycle, clear the timeout counter, go to CONVERT.
  - CONVERT
    - adc_chan is held stable.
    - On adc_done: write adc_data to result[adc_chan], set valid[adc_chan], set ptr=adc_chan+1, go to SELECT.
    - If TIMEOUT cycles pass without adc_done: set timeout_err, clear valid[adc_chan], advance ptr the same way, go to SELECT.
    - adc_done arriving in any state other than CONVERT is ignored.
  - DONE
    - scan_done=1 for one cycle, then IDLE.
- enable falling mid-round: the current START/CONVERT runs to completion (no ADC abort). The FSM then returns to IDLE with no scan_done; stored results are kept.
- Latency:
  - adc_start is asserted 2 cycles after the tick when the driver is idle.
  - rd_data/rd_valid are registered and reflect rd_chan one cycle later.
  - A result written in cycle N is readable on rd_data from cycle N+1 when rd_chan already addresses it.
- timeout_err: set has priority over clr_err in the same cycle.
- Round snapshot: ch_mask, manual and man_chan changes mid-round take effect at the next round only.

Optional Feature:
- Macro: ADC_SCAN_AVG_EN.
- When defined:
  - Each selected channel is converted 4 times back-to-back, each with its own START/CONVERT handshake.
  - Samples are summed in a DATA_W+2 accumulator; result stores sum>>2 (truncating).
  - Any timeout among the 4 abandons that channel: timeout_err set, valid cleared, no store.
- When undefined: a single conversion per channel, exactly as above, with no accumulator logic.

Test Plan:
- Auto scan, ch_mask=8'b1010_0101, SCAN_DIV=16, ADC model returns 12'h100+chan after 5 cycles. Required:
  - adc_chan order 0,2,5,7.
  - scan_done pulses once.
  - Reading rd_chan 5 gives 12'h105 with rd_valid=1; reading rd_chan 1 gives rd_valid=0.
- Manual mode, man_chan=4'd3, then 4'd12. Required: only channel 3 is converted, then only channel 7 (clamped); one adc_start per round.
- adc_busy held high 10 cycles after the tick. Required: adc_start stays low, then asserts exactly once in the first cycle after adc_busy falls.
- ADC model never returns adc_done on channel 2, TIMEOUT=20. Required:
  - Start to channel-3 start gap is TIMEOUT+2 cycles.
  - timeout_err=1 and valid[2]=0; the round still completes with scan_done.
  - clr_err asserted alone clears timeout_err.
- enable dropped 1 cycle after adc_start on channel 0 (mask=8'hFF). Required: the conversion stores, no further adc_start, no scan_done; reset_n low mid-CONVERT clears all outputs and valids immediately.
- ADC_SCAN_AVG_EN defined, samples 100,101,102,104 on channel 1. Required: result[1]=101, 4 adc_start pulses for the channel.
